hnf_qos_rr_sel: RTL



---
 rtl/hnf_qos_rr_sel_pkg.sv | 7 +
 rtl/hnf_rr_find_first.sv | 23 ++
 rtl/hnf_qos_rr_sel.sv | 84 ++++++++
 3 files changed

// File: rtl/hnf_qos_rr_sel_pkg.sv
// hnf_qos_rr_sel_pkg: shared QoS selector widths, thresholds and selection-mode encodings
package hnf_qos_rr_sel_pkg;
   localparam int HNF_QOS_PRI_WIDTH = 2;
   localparam int HNF_QOS_STARVE_TH = 15;
   localparam logic HNF_SEL_MODE_FIXED = 1'b0;
   localparam logic HNF_SEL_MODE_RR = 1'b1;
endpackage

// File: rtl/hnf_rr_find_first.sv
// hnf_rr_find_first: first set bit strictly above ptr, wrapping to the lowest set bit
module hnf_rr_find_first #(
   parameter int ENTRIES_NUM = 16,
   parameter int IDX_WIDTH = 4
) (
   input  logic [ENTRIES_NUM-1:0] vec,
   input  logic [IDX_WIDTH-1:0]   ptr,
   output logic [ENTRIES_NUM-1:0] onehot,
   output logic [IDX_WIDTH-1:0]   idx,
   output logic                   found
);
   logic [ENTRIES_NUM-1:0] hi;
   logic [ENTRIES_NUM-1:0] src;
   always_comb begin
      hi = '0;
      for (int i = 0; i < ENTRIES_NUM; i++) hi[i] = vec[i] && (IDX_WIDTH'(i) > ptr);
      src = |hi ? hi : vec;
      idx = '0;
      for (int i = ENTRIES_NUM-1; i >= 0; i--) if (src[i]) idx = IDX_WIDTH'(i);
      found = |vec;
      onehot = {{(ENTRIES_NUM-1){1'b0}}, found} << idx;
   end
endmodule

// File: rtl/hnf_qos_rr_sel.sv
// hnf_qos_rr_sel: multi-level QoS entry selector with per-level round-robin pointers,
// starvation promotion and a grant lock for multi-cycle ownership
module hnf_qos_rr_sel
   import hnf_qos_rr_sel_pkg::*;
#(
   parameter int ENTRIES_NUM = 16,
   parameter int PRI_WIDTH = HNF_QOS_PRI_WIDTH,
   parameter int IDX_WIDTH = 4,
   parameter int STARVE_TH = HNF_QOS_STARVE_TH,
   parameter int CNT_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ENTRIES_NUM-1:0]           req_entry_vec,
   input  logic [ENTRIES_NUM*PRI_WIDTH-1:0] req_entry_pri,
   input  logic                             sel_mode,
   input  logic                             upd_start_entry,
   input  logic                             lock_req,
   output logic [ENTRIES_NUM-1:0]           req_entry_ptr_sel,
   output logic                             sel_vld,
   output logic [IDX_WIDTH-1:0]             sel_idx,
   output logic [PRI_WIDTH-1:0]             sel_pri,
   output logic                             lock_active
);
   localparam int PRI_LVL_NUM = 2**PRI_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   logic [IDX_WIDTH-1:0] last_q [PRI_LVL_NUM];
   logic [CNT_WIDTH-1:0] starve_cnt_q [PRI_LVL_NUM];
   logic lock_q;
   logic [IDX_WIDTH-1:0] lock_idx_q;
   logic [PRI_LVL_NUM-1:0][ENTRIES_NUM-1:0] lvl_vec;
   logic [PRI_LVL_NUM-1:0][ENTRIES_NUM-1:0] ff_oh;
   logic [IDX_WIDTH-1:0] ff_idx [PRI_LVL_NUM];
   logic [PRI_LVL_NUM-1:0] ff_found;
   logic [PRI_LVL_NUM-1:0] urg;
   logic [PRI_WIDTH-1:0] lvl;
   logic lock_hit;
   always_comb begin
      lvl_vec = '0;
      for (int l = 0; l < PRI_LVL_NUM; l++)
         for (int i = 0; i < ENTRIES_NUM; i++)
            lvl_vec[l][i] = req_entry_vec[i] && (req_entry_pri[i*PRI_WIDTH +: PRI_WIDTH] == PRI_WIDTH'(l));
   end
   // fixed mode parks the search pointer on the last entry so the search starts at entry 0
   for (genvar l = 0; l < PRI_LVL_NUM; l++) begin : g_lvl
      hnf_rr_find_first #(.ENTRIES_NUM(ENTRIES_NUM), .IDX_WIDTH(IDX_WIDTH)) u_ff (
         .vec    (lvl_vec[l]),
         .ptr    (sel_mode == HNF_SEL_MODE_RR ? last_q[l] : IDX_WIDTH'(ENTRIES_NUM-1)),
         .onehot (ff_oh[l]),
         .idx    (ff_idx[l]),
         .found  (ff_found[l])
      );
   end
   always_comb begin
      urg = '0;
      for (int l = 0; l < PRI_LVL_NUM; l++) urg[l] = ff_found[l] && (starve_cnt_q[l] >= CNT_WIDTH'(STARVE_TH));
      lvl = '0;
      for (int l = 0; l < PRI_LVL_NUM; l++) if (|urg ? urg[l] : ff_found[l]) lvl = PRI_WIDTH'(l);
      lock_hit = lock_q && req_entry_vec[lock_idx_q];
      sel_vld = |req_entry_vec;
      sel_idx = lock_hit ? lock_idx_q : ff_idx[lvl];
      sel_pri = lock_hit ? req_entry_pri[lock_idx_q*PRI_WIDTH +: PRI_WIDTH] : lvl;
      req_entry_ptr_sel = lock_hit ? {{(ENTRIES_NUM-1){1'b0}}, 1'b1} << lock_idx_q : ff_oh[lvl];
      lock_active = lock_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= '{default: IDX_WIDTH'(ENTRIES_NUM-1)};
         starve_cnt_q <= '{default: '0};
         lock_q <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         if (lock_q && !req_entry_vec[lock_idx_q]) lock_q <= 1'b0;
         if (upd_start_entry && sel_vld) begin
            last_q[sel_pri] <= sel_idx;
            for (int l = 0; l < PRI_LVL_NUM; l++)
               starve_cnt_q[l] <= (PRI_WIDTH'(l) == sel_pri || !ff_found[l]) ? '0 :
                  starve_cnt_q[l] + {{(CNT_WIDTH-1){1'b0}}, starve_cnt_q[l] != CNT_MAX};
            lock_q <= lock_req;
            lock_idx_q <= sel_idx;
         end
      end
   end
endmodule
